// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM states, digit
// geometry and the digit-validity helper used by the digit MAC.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_MAX_DIGIT = 9;

    function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] digit);
        return digit > BCD_DIGIT_W'(BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// One Horner step of decimal-to-binary conversion: acc*10 + digit, with a
// flag for digits outside 0..9. Purely combinational.
module bcd_digit_mac
    import bcd_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]           acc,
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [W-1:0]           acc_next,
    output logic                   invalid
);

    // x10 as shift-and-add; the result always fits in W bits for legal input
    assign acc_next = (acc << 3) + (acc << 1) + W'(digit);
    assign invalid  = digit_invalid(digit);

endmodule

// File: rtl/bcd2binary.sv
// Sequential K-digit packed-BCD to binary converter: one digit per cycle,
// MSD first, result and invalid-digit flag registered on a one-cycle done.
module bcd2binary
    import bcd_pkg::*;
#(
    parameter int K = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [K*BCD_DIGIT_W-1:0] bcd,
    output logic                     busy,
    output logic                     done,
    output logic [K*BCD_DIGIT_W-1:0] bin,
    output logic                     err
);

    localparam int W     = K * BCD_DIGIT_W;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K - 1);

    state_t           state;
    state_t           state_next;
    logic [W-1:0]     sreg;
    logic [W-1:0]     acc;
    logic [CNT_W-1:0] cnt;
    logic             invalid;

    logic [W-1:0]     mac_acc;
    logic             mac_invalid;

    bcd_digit_mac #(
        .W (W)
    ) u_mac (
        .acc      (acc),
        .digit    (sreg[W-1 -: BCD_DIGIT_W]),
        .acc_next (mac_acc),
        .invalid  (mac_invalid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_CONV;
            ST_CONV: if (cnt == LAST_CNT) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: datapath registers are all reset so an aborted conversion leaves
    // nothing behind that a later result could depend on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            acc     <= '0;
            cnt     <= '0;
            invalid <= 1'b0;
            bin     <= '0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sreg    <= bcd;
                        acc     <= '0;
                        cnt     <= '0;
                        invalid <= 1'b0;
                    end
                end
                ST_CONV: begin
                    acc  <= mac_acc;
                    sreg <= sreg << BCD_DIGIT_W;
                    cnt  <= cnt + 1'b1;
                    if (mac_invalid) invalid <= 1'b1;
                end
                ST_DONE: begin
                    bin  <= invalid ? '0 : acc;
                    err  <= invalid;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == ST_CONV) || (state == ST_DONE);

endmodule

// File: tb/tb_bcd2binary.sv
// Self-checking bench for bcd2binary at K=2, K=4 and K=1: a vector table for
// the K=2 datapath plus directed sequences for held start, reset and latency.
module tb_bcd2binary;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start2, busy2, done2, err2;
    logic [7:0]  bcd2, bin2;
    logic        start4, busy4, done4, err4;
    logic [15:0] bcd4, bin4;
    logic        start1, busy1, done1, err1;
    logic [3:0]  bcd1, bin1;

    int total = 0;
    int bad   = 0;
    int cur_k = 2;

    logic        m_busy, m_done, m_err;
    logic [31:0] m_bin;

    always #5 clk = ~clk;

    bcd2binary #(.K(2)) dut2 (.clk(clk), .rst_n(rst_n), .start(start2), .bcd(bcd2),
                              .busy(busy2), .done(done2), .bin(bin2), .err(err2));
    bcd2binary #(.K(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(start4), .bcd(bcd4),
                              .busy(busy4), .done(done4), .bin(bin4), .err(err4));
    bcd2binary #(.K(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start1), .bcd(bcd1),
                              .busy(busy1), .done(done1), .bin(bin1), .err(err1));

    always_comb begin
        m_busy = busy2;
        m_done = done2;
        m_err  = err2;
        m_bin  = 32'(bin2);
        if (cur_k == 4) begin
            m_busy = busy4; m_done = done4; m_err = err4; m_bin = 32'(bin4);
        end else if (cur_k == 1) begin
            m_busy = busy1; m_done = done1; m_err = err1; m_bin = 32'(bin1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int k, input logic s, input logic [31:0] v);
        case (k)
            1:       begin start1 = s; bcd1 = v[3:0];  end
            4:       begin start4 = s; bcd4 = v[15:0]; end
            default: begin start2 = s; bcd2 = v[7:0];  end
        endcase
    endtask

    // Full conversion with edge-exact latency checks; bcd is scrambled after capture.
    task automatic run_conv(input int k, input logic [31:0] val, input logic [31:0] exp_bin,
                            input logic exp_err, input string tag);
        cur_k = k;
        drive(k, 1'b1, val);
        @(posedge clk);
        #1;
        drive(k, 1'b0, ~val);
        check({tag, " busy e0"}, 32'(m_busy), 32'd1);
        check({tag, " done e0"}, 32'(m_done), 32'd0);
        for (int e = 1; e <= k; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s busy e%0d", tag, e), 32'(m_busy), 32'd1);
            check($sformatf("%s done e%0d", tag, e), 32'(m_done), 32'd0);
        end
        @(posedge clk);
        #1;
        check({tag, " done pulse"}, 32'(m_done), 32'd1);
        check({tag, " busy in done"}, 32'(m_busy), 32'd0);
        check({tag, " bin"}, m_bin, exp_bin);
        check({tag, " err"}, 32'(m_err), 32'(exp_err));
        @(posedge clk);
        #1;
        check({tag, " done drop"}, 32'(m_done), 32'd0);
        check({tag, " bin hold"}, m_bin, exp_bin);
        check({tag, " err hold"}, 32'(m_err), 32'(exp_err));
    endtask

    typedef struct {
        logic [7:0] bcd;
        logic [7:0] bin;
        logic       err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'h42, 8'h2A, 1'b0};
        vecs[1] = '{8'h99, 8'h63, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b0};
        vecs[3] = '{8'h3A, 8'h00, 1'b1};
        vecs[4] = '{8'h15, 8'h0F, 1'b0};
        vecs[5] = '{8'hA5, 8'h00, 1'b1};
        vecs[6] = '{8'h09, 8'h09, 1'b0};
        vecs[7] = '{8'h50, 8'h32, 1'b0};

        rst_n = 1'b0;
        drive(2, 1'b0, 0);
        drive(4, 1'b0, 0);
        drive(1, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 32'(busy2), 32'd0);
        check("rst done", 32'(done2), 32'd0);
        check("rst bin",  32'(bin2),  32'd0);
        check("rst err",  32'(err2),  32'd0);
        check("rst busy4", 32'(busy4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i])
            run_conv(2, 32'(vecs[i].bcd), 32'(vecs[i].bin), vecs[i].err,
                     $sformatf("vec%0d", i));

        // start held for 10 edges: accepted at 0, 4, 8 only; bcd is 0x27 only there
        cur_k = 2;
        drive(2, 1'b1, 32'h27);
        for (int e = 0; e <= 12; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("held done e%0d", e), 32'(done2),
                  32'((e == 3) || (e == 7) || (e == 11)));
            check($sformatf("held busy e%0d", e), 32'(busy2),
                  32'((e <= 11) && ((e % 4) != 3)));
            if ((e == 3) || (e == 7) || (e == 11))
                check($sformatf("held bin e%0d", e), 32'(bin2), 32'h1B);
            drive(2, (e + 1) <= 9, ((e + 1) % 4 == 0) ? 32'h27 : 32'h81);
        end

        // reset asserted just after edge 1 of a conversion
        drive(2, 1'b1, 32'h42);
        @(posedge clk);
        #1;
        drive(2, 1'b0, 32'h42);
        @(posedge clk);
        #1;
        check("pre-abort busy", 32'(busy2), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy2), 32'd0);
        check("abort done", 32'(done2), 32'd0);
        check("abort bin",  32'(bin2),  32'd0);
        check("abort err",  32'(err2),  32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort no done c%0d", c), 32'(done2), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_conv(2, 32'h42, 32'h2A, 1'b0, "post_rst");

        run_conv(4, 32'h9999, 32'h270F, 1'b0, "k4 9999");
        run_conv(4, 32'h1234, 32'h04D2, 1'b0, "k4 1234");
        run_conv(4, 32'h12F4, 32'h0000, 1'b1, "k4 12F4");
        run_conv(4, 32'h0001, 32'h0001, 1'b0, "k4 0001");

        run_conv(1, 32'h7, 32'h7, 1'b0, "k1 7");
        run_conv(1, 32'h9, 32'h9, 1'b0, "k1 9");
        run_conv(1, 32'hB, 32'h0, 1'b1, "k1 B");
        run_conv(1, 32'h0, 32'h0, 1'b0, "k1 0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
